// File: rtl/mem_pll_rst_seq_if.sv
// Control and status bundle between the DDR3 PLL reset sequencer and its surroundings.
// The master side is the sequencer; the slave side is the PLL / memory controller.
interface mem_pll_rst_seq_if;
    logic       pll_lock;
    logic       calib_done;
    logic       force_relock;
    logic       pll_reset;
    logic       mem_rst_n;
    logic       ready;
    logic       error;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;

    modport master (
        input  pll_lock, calib_done, force_relock,
        output pll_reset, mem_rst_n, ready, error, retry_cnt, state_o
    );

    modport slave (
        output pll_lock, calib_done, force_relock,
        input  pll_reset, mem_rst_n, ready, error, retry_cnt, state_o
    );
endinterface

// File: rtl/mem_pll_rst_seq.sv
// DDR3 memory-clock PLL reset/lock sequencer: pulses the PLL reset, qualifies lock,
// releases the controller reset, waits for calibration, and retries on failure.
module mem_pll_rst_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned CALIB_TIMEOUT = 4194304,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_pll_rst_seq_if.master  bus
);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StReady    = 3'd4,
        StFail     = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       lock_sync, calib_sync;
    logic             lock_s, calib_s, take_retry;

    assign lock_s  = lock_sync[1];
    assign calib_s = calib_sync[1];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync  <= 2'b00;
            calib_sync <= 2'b00;
        end else begin
            lock_sync  <= {lock_sync[0], bus.pll_lock};
            calib_sync <= {calib_sync[0], bus.calib_done};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        retry_d    = retry_q;
        take_retry = 1'b0;
        if (bus.force_relock) begin
            state_d = StPllRst;
            cnt_d   = '0;
            retry_d = 4'd0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                StStable: begin
                    // A lock drop restarts qualification without consuming a retry.
                    if (!lock_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        take_retry = 1'b1;
                    end else if (calib_s) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else if (cnt_q == CALIB_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                StReady: begin
                    cnt_d = '0;
                    if (!lock_s) take_retry = 1'b1;
                end
                StFail: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end
            endcase

            if (take_retry) begin
                cnt_d = '0;
                if (retry_q >= RETRY_MAX) begin
                    state_d = StFail;
                end else begin
                    state_d = StPllRst;
                    retry_d = retry_q + 4'd1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they settle together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StPllRst;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            bus.pll_reset <= 1'b1;
            bus.mem_rst_n <= 1'b0;
            bus.ready     <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            bus.pll_reset <= (state_d == StPllRst) || (state_d == StFail);
            bus.mem_rst_n <= (state_d == StRun) || (state_d == StReady);
            bus.ready     <= (state_d == StReady);
            bus.error     <= (state_d == StFail);
        end
    end

    assign bus.retry_cnt = retry_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mem_pll_rst_seq.sv
// Directed bench for mem_pll_rst_seq: bring-up, glitch, timeouts, FAIL, relock and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_pll_rst_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_pll_rst_seq_if bus ();

    mem_pll_rst_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .CALIB_TIMEOUT(64),
        .MAX_RETRY    (2),
        .CNT_W        (24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st, input logic pr,
                              input logic mr, input logic rd, input logic er,
                              input logic [3:0] rc);
        chk({tag, ".state"},     32'(bus.state_o),   32'(st));
        chk({tag, ".pll_reset"}, 32'(bus.pll_reset), 32'(pr));
        chk({tag, ".mem_rst_n"}, 32'(bus.mem_rst_n), 32'(mr));
        chk({tag, ".ready"},     32'(bus.ready),     32'(rd));
        chk({tag, ".error"},     32'(bus.error),     32'(er));
        chk({tag, ".retry_cnt"}, 32'(bus.retry_cnt), 32'(rc));
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.pll_lock     = 1'b0;
        bus.calib_done   = 1'b0;
        bus.force_relock = 1'b0;

        cyc(2);
        expect_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Nominal bring-up; N0 = release edge
        rst_n = 1'b1;
        cyc(3);  expect_all("rst_pulse_last", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("wait_lock", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(6);  bus.pll_lock = 1'b1;                      // N10
        cyc(2);  expect_all("lock_sync", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("stable_enter", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(7);  expect_all("stable_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("run", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(20); bus.calib_done = 1'b1;                    // N41
        cyc(2);  expect_all("calib_sync", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("ready", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // calib_done dropping alone must not disturb READY
        bus.calib_done = 1'b0;
        cyc(5);  expect_all("calib_drop", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // Lock loss in READY
        bus.pll_lock = 1'b0;
        cyc(2);  expect_all("lockloss_sync", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1);  expect_all("lockloss", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);

        // Lock glitch at STABLE count 5; retry count must not move
        bus.pll_lock = 1'b1;
        cyc(3);  expect_all("retry_pulse", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("retry_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("g_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(5);  bus.pll_lock = 1'b0;
        cyc(1);  bus.pll_lock = 1'b1;
        cyc(1);  expect_all("g_sync", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("g_back", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("g_requal", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(7);  expect_all("g_stable_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("g_run", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);

        // Asynchronous reset in RUN
        rst_n = 1'b0;
        #1;      expect_all("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(2);
        bus.pll_lock = 1'b0;
        rst_n        = 1'b1;                               // R0
        cyc(3);  expect_all("r_pulse", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("r_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Lock timeouts to FAIL
        cyc(31); expect_all("to1_before", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("to1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(3);  expect_all("to1_pulse", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1);  expect_all("to1_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(32); expect_all("to2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        cyc(4);  expect_all("to2_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        cyc(31); expect_all("to3_before", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        cyc(1);  expect_all("fail", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        bus.pll_lock = 1'b1;
        cyc(5);  expect_all("fail_hold", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);

        // force_relock out of FAIL, then full bring-up; F0 = pulse edge
        bus.force_relock = 1'b1;
        cyc(1);  bus.force_relock = 1'b0;
        expect_all("relock", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(3);  expect_all("rl_pulse", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("rl_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("rl_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(7);  expect_all("rl_stable_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("rl_run", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        bus.calib_done = 1'b1;
        cyc(2);  expect_all("rl_calib_sync", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("rl_ready", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // force_relock while already in PLL_RST restarts the pulse counter
        bus.force_relock = 1'b1;
        cyc(1);  bus.force_relock = 1'b0;
        expect_all("fr_ready", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  bus.force_relock = 1'b1;
        cyc(1);  bus.force_relock = 1'b0;
        cyc(3);  expect_all("fr_restart", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1);  expect_all("fr_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
